instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Fetch-side responder to the opcode decoder: holds the PC, requests instruction words from instruction memory, and presents each word (with its PC) to decode/execute.
- Consumes the decoder's 2-bit PC-source select plus the ALU branch-condition bit to compute the next PC when the current instruction retires.
- Sits between instruction memory and the decoder/datapath.
- Allows one outstanding memory request and one buffered instruction.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width (fixed 32 for MIPS jump formation).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  instruction word valid this cycle.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_data  out  32  buffered instruction word.
- inst_pc  out  32  PC of inst_data.
- inst_ready  in  1  decode/execute retires the instruction this cycle.
- pc_src  in  2  decoder PC select: 00 seq, 01 jump, 10 branch, 11 reserved.
- branch_taken  in  1  ALU condition result for the branch in inst_data.
- retired_count  out  32  number of retired instructions, wraps modulo 2^32.
- err_flag  out  1  sticky protocol/encoding error.

Behaviour:
- Clock is clk. Reset is rst: synchronous and active-high.
- Reset values:
  - state = S_REQ, pc = RESET_PC.
  - imem_req_valid = 1 from the first cycle after reset; imem_req_addr = RESET_PC.
  - inst_valid = 0, inst_data = 0, inst_pc = 0.
  - retired_count = 0, err_flag = 0.
- FSM states: S_REQ, S_WAIT, S_HOLD.
- S_REQ:
  - imem_req_valid = 1 and imem_req_addr = pc; both are held stable until accepted.
  - Transfer occurs on valid & ready; the next state is S_WAIT.
- S_WAIT:
  - imem_req_valid = 0.
  - On imem_rsp_valid: register inst_data = imem_rsp_data and inst_pc = pc, then go to S_HOLD.
  - inst_valid rises the cycle after the response arrives.
- S_HOLD:
  - inst_valid = 1, with inst_data and inst_pc stable until inst_ready.
  - On inst_valid & inst_ready: pc <= next_pc, retired_count += 1, inst_valid <= 0, state <= S_REQ.
  - The next request therefore appears one cycle after retirement.
- next_pc, using p4 = inst_pc + 4 (32-bit wrap):
  - 00 → p4.
  - 01 → {p4[31:28], inst_data[25:0], 2'b00}.
  - 10 → branch_taken ? p4 + (sign_extend(inst_data[15:0]) << 2) : p4. Arithmetic is mod 2^32.
  - 11 → p4, and err_flag is set.
- pc_src and branch_taken are sampled only in the retirement cycle.
- Latency:
  - Request accepted at cycle N → response at cycle M ≥ N+1 → inst_valid at M+1.
  - Best-case throughput is one instruction per 3 cycles.
- imem_rsp_valid in S_REQ or S_HOLD is ignored and sets err_flag. The buffered instruction is never overwritten.
- inst_ready while inst_valid = 0 has no effect.
- err_flag is sticky; only rst clears it.
- rst in any state, including S_WAIT with a request in flight, returns the block to reset values. A late response arriving in the S_REQ that follows reset is ignored and sets err_flag. Memory must not return responses across reset.
- PC bits [1:0] are never nonzero, because all next_pc forms are word-aligned.

Decomposition:
- Shared package (cpu_pkg) holds:
  - PC_SRC_SEQ = 2'b00, PC_SRC_JUMP = 2'b01, PC_SRC_BRANCH = 2'b10, PC_SRC_RSVD = 2'b11. The decoder uses the same constants.
  - The fetch_state_t enum (S_REQ, S_WAIT, S_HOLD).
  - RESET_PC default.
- One combinational sub-module, pc_next_calc: inputs inst_pc, inst_data, pc_src, branch_taken; outputs next_pc and rsvd_sel.
- FSM, buffer and counter stay in instr_fetch.

Test Plan:
- Reset then memory always ready, 1-cycle response, inst_ready = 1, pc_src = 00 → inst_pc sequence 0x0, 0x4, 0x8; inst_valid pulses every 3 cycles; retired_count = 3 after the third retire.
- Instruction 0x0800_0010 at PC 0x0000_0004, pc_src = 01 → next imem_req_addr = 0x0000_0040.
- Branch at PC 0x100 with imm 0xFFFE:
  - branch_taken = 1 → next addr 0x0FC.
  - branch_taken = 0 → next addr 0x104.
- Backpressure: hold inst_ready = 0 for 5 cycles and imem_req_ready = 0 for 3 cycles → inst_data, inst_pc and imem_req_addr stay stable; no duplicate request; one retire counted.
- Assert rst during S_WAIT at pc 0x20 → next cycle req addr = RESET_PC, inst_valid = 0, retired_count = 0. A stray response in S_REQ sets err_flag.
- pc_src = 11 at retire of PC 0x10 → next addr 0x14, err_flag = 1 and stays 1 until rst.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and the opcode decoder.
//   PC_SRC_*          : decoder PC-source select encodings
//   fetch_state_t     : fetch FSM states
//   RESET_PC_DEFAULT  : default PC value loaded on reset
package cpu_pkg;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b10;
    localparam logic [1:0] PC_SRC_RSVD   = 2'b11;

    // Explicit encodings keep the legacy state values.
    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_HOLD = 2'b10
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC computation for the retiring instruction.
//   inst_pc      : PC of the retiring instruction
//   inst_data    : retiring instruction word (jump target / branch imm)
//   pc_src       : decoder PC select (seq / jump / branch / reserved)
//   branch_taken : ALU condition for a branch
//   next_pc      : PC of the next instruction to fetch
//   rsvd_sel     : reserved pc_src encoding was presented
module pc_next_calc
    import cpu_pkg::*;
(
    input  logic [31:0] inst_pc,
    input  logic [31:0] inst_data,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    output logic [31:0] next_pc,
    output logic        rsvd_sel
);

    logic [31:0] p4;
    logic [31:0] br_off;
    logic        unused_opcode;

    assign p4     = inst_pc + 32'd4;
    // Sign-extended 16-bit immediate scaled to a byte offset.
    assign br_off = {{14{inst_data[15]}}, inst_data[15:0], 2'b00};
    assign unused_opcode = ^inst_data[31:26];

    always_comb begin
        next_pc  = p4;
        rsvd_sel = 1'b0;
        case (pc_src)
            PC_SRC_SEQ:    next_pc = p4;
            PC_SRC_JUMP:   next_pc = {p4[31:28], inst_data[25:0], 2'b00};
            PC_SRC_BRANCH: next_pc = branch_taken ? (p4 + br_off) : p4;
            default: begin
                next_pc  = p4;
                rsvd_sel = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, issues one instruction-memory
// request at a time, buffers the returned word for decode and advances
// the PC when decode/execute retires it.
//   clk, rst        : clock, synchronous active-high reset
//   imem_req_*      : request channel to instruction memory
//   imem_rsp_*      : response channel from instruction memory
//   inst_*          : buffered instruction presented to decode
//   pc_src          : decoder PC select, sampled at retirement
//   branch_taken    : ALU branch condition, sampled at retirement
//   retired_count   : retired instruction count (wraps)
//   err_flag        : sticky protocol / encoding error
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              inst_valid,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic [1:0]        pc_src,
    input  logic              branch_taken,
    output logic [31:0]       retired_count,
    output logic              err_flag
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       next_pc;
    logic              rsvd_sel;

    pc_next_calc u_pc_next_calc (
        .inst_pc      (inst_pc),
        .inst_data    (inst_data),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .next_pc      (next_pc),
        .rsvd_sel     (rsvd_sel)
    );

    // Request is driven straight from the state so it is stable until accepted.
    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_REQ;
            pc            <= RESET_PC;
            inst_valid    <= 1'b0;
            inst_data     <= '0;
            inst_pc       <= '0;
            retired_count <= '0;
            err_flag      <= 1'b0;
        end else begin
            // A response with no request in flight is dropped and flagged.
            if (imem_rsp_valid && state != S_WAIT)
                err_flag <= 1'b1;

            case (state)
                S_REQ: begin
                    if (imem_req_ready)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        inst_data  <= imem_rsp_data;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_valid && inst_ready) begin
                        pc            <= next_pc;
                        retired_count <= retired_count + 32'd1;
                        inst_valid    <= 1'b0;
                        state         <= S_REQ;
                        if (rsvd_sel)
                            err_flag <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule
